display_update_ctrl: RTL and testbench
======================================

DISPLAY_UPDATE_CTRL -- requirements
Module: display_update_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles REQ waits for ACK.
REQ-002 SHALL have parameter BLINK_FRAMES, default 30: frames per alarm blink half-period.
REQ-003 SHALL have port CLK  in  1  system clock; all logic on posedge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port VS  in  1  vertical sync from the sync generator, active-low, same clock domain.
REQ-006 SHALL have port ALARMA_IN  in  1  raw alarm flag, active-low.
REQ-007 SHALL have port REQ  out  1  RTC register read request.
REQ-008 SHALL have port ADDR  out  8  RTC register address.
REQ-009 SHALL have port ACK  in  1  RTC read acknowledge; RDATA valid in the same cycle.
REQ-010 SHALL have port RDATA  in  8  RTC read data, BCD.
REQ-011 SHALL have ports DIA_T, MES_T, ANO_T, HORA_T, MINUTO_T, SEGUNDO_T, HORAT_T, MINUTOT_T, SEGUNDOT_T  out  8 each  committed BCD fields to the display.
REQ-012 SHALL have port ALARMA  out  1  blinking alarm indicator to the display, active-low.
REQ-013 SHALL have port BUSY  out  1  high while a read sequence runs.
REQ-014 SHALL have port ERR  out  1  one-cycle pulse on timeout or BCD error.

Function
REQ-015 Frame start SHALL be the VS falling edge, detected against a registered copy of VS (1 cycle detection latency).
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, GAP, COMMIT.
REQ-017 IDLE->ISSUE on frame start; a frame start in any other state SHALL be ignored (no queueing).
REQ-018 Read order, index 0..8, SHALL be: day 0x24, month 0x25, year 0x26, hour 0x23, minute 0x22, second 0x21, timer-hour 0x43, timer-minute 0x42, timer-second 0x41.
REQ-019 ISSUE SHALL drive ADDR = table[index] and REQ = 1, then go to WAIT.
REQ-020 In WAIT, REQ and ADDR SHALL be held stable until ACK = 1.
REQ-021 On ACK = 1, RDATA SHALL be captured into shadow[index] and the FSM SHALL go to GAP.
REQ-022 GAP SHALL drive REQ = 0 for exactly one cycle, then increment index.
- index < 9: next state ISSUE.
- index reaches 9: next state COMMIT.
REQ-023 WAIT SHALL count cycles. When TIMEOUT cycles pass without ACK:
- drop REQ;
- pulse ERR;
- discard the shadow;
- return to IDLE with no commit.
REQ-024 COMMIT SHALL update all valid fields in one cycle, then return to IDLE.
- A field is valid only if both nibbles are <= 9.
- Invalid fields SHALL keep their prior value, and ERR SHALL pulse.
REQ-025 BUSY SHALL be 1 in every state except IDLE.
REQ-026 An ACK received outside WAIT SHALL be ignored.
REQ-027 The blink counter SHALL count frame starts while ALARMA_IN = 0, wrapping at BLINK_FRAMES-1 and toggling a phase bit on each wrap.
REQ-028 ALARMA SHALL be 0 only when ALARMA_IN = 0 and phase = 0.
REQ-029 When ALARMA_IN = 1, the blink counter and phase SHALL clear in the next cycle.

Reset
REQ-030 While RST = 0, the block SHALL force:
- all field outputs and the shadow to 0x00;
- REQ = 0, ADDR = 0x00, BUSY = 0, ERR = 0, ALARMA = 1;
- FSM = IDLE, index = 0, blink counter and phase = 0.
REQ-031 A reset during a sequence SHALL abort it immediately with no commit; the first frame start after RST rises SHALL start a fresh sequence.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the nine-entry RTC address table, and the TIMEOUT and BLINK_FRAMES defaults.
REQ-033 The alarm blink logic SHALL be a sub-module named alarm_blink (inputs: frame-start strobe, ALARMA_IN; output: ALARMA).

Verification
REQ-034 Frame start with an RTC model acking after 2 cycles and data 0x15,0x08,0x24,0x13,0x45,0x30,0x00,0x05,0x59 -> the outputs SHALL show exactly those nine values at once on the COMMIT cycle, with no intermediate partial update.
REQ-035 ACK withheld on index 3 -> REQ SHALL fall after 255 cycles, ERR SHALL pulse once, and all outputs SHALL be unchanged.
REQ-036 SEGUNDO data 0x6A with all other fields valid -> SEGUNDO_T SHALL keep its old value, the other eight fields SHALL update, and ERR SHALL pulse.
REQ-037 Second VS falling edge during WAIT -> no restart and the index SHALL be unchanged; exactly 9 requests SHALL be issued for the frame.
REQ-038 ALARMA_IN = 0 for 120 frames -> ALARMA SHALL be 0 for frames 0-29, 1 for 30-59, 0 for 60-89, 1 for 90-119; ALARMA_IN = 1 -> ALARMA SHALL be 1 and the counter SHALL be 0.
REQ-039 RST low at index 5 -> the outputs SHALL hold the REQ-030 reset values while RST is low; after RST rises, the next frame start SHALL issue from index 0.

Source files
------------

// File: rtl/display_update_ctrl_pkg.sv
// rtl/display_update_ctrl_pkg.sv - FSM encoding, RTC address table and default timing for display_update_ctrl
package display_update_ctrl_pkg;

    localparam int TIMEOUT_DEF      = 255;
    localparam int BLINK_FRAMES_DEF = 30;
    localparam int NUM_FIELDS       = 9;
    localparam int IDX_W            = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_COMMIT
    } state_t;

    // Read order: date fields first, then time, then the timer registers.
    function automatic logic [7:0] rtc_addr(input logic [IDX_W-1:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = 8'h24;
            4'd1:    a = 8'h25;
            4'd2:    a = 8'h26;
            4'd3:    a = 8'h23;
            4'd4:    a = 8'h22;
            4'd5:    a = 8'h21;
            4'd6:    a = 8'h43;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h41;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/display_update_ctrl_alarm_blink.sv
// rtl/display_update_ctrl_alarm_blink.sv - frame-counted blink of the active-low alarm indicator
module alarm_blink
    import display_update_ctrl_pkg::*;
#(
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic FRAME_START,
    input  logic ALARMA_IN,
    output logic ALARMA
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_alarma;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_phase_nxt;

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        if (ALARMA_IN) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b0;
        end else if (FRAME_START) begin
            if (r_cnt == CW'(BLINK_FRAMES - 1)) begin
                w_cnt_nxt   = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    // Indicator is registered from the next phase so it tracks the counter without an extra cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_alarma <= 1'b1;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_alarma <= ALARMA_IN | w_phase_nxt;
        end
    end

    assign ALARMA = r_alarma;

endmodule

// File: rtl/display_update_ctrl.sv
// rtl/display_update_ctrl.sv - per-frame RTC register sweep with atomic commit of BCD display fields
module display_update_ctrl
    import display_update_ctrl_pkg::*;
#(
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       VS,
    input  logic       ALARMA_IN,
    output logic       REQ,
    output logic [7:0] ADDR,
    input  logic       ACK,
    input  logic [7:0] RDATA,
    output logic [7:0] DIA_T,
    output logic [7:0] MES_T,
    output logic [7:0] ANO_T,
    output logic [7:0] HORA_T,
    output logic [7:0] MINUTO_T,
    output logic [7:0] SEGUNDO_T,
    output logic [7:0] HORAT_T,
    output logic [7:0] MINUTOT_T,
    output logic [7:0] SEGUNDOT_T,
    output logic       ALARMA,
    output logic       BUSY,
    output logic       ERR
);

    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LAST_IDX = NUM_FIELDS - 1;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [TW-1:0]    r_timer;
    logic             r_vs_d;
    logic             r_req;
    logic [7:0]       r_addr;
    logic             r_busy;
    logic             r_err;
    logic [7:0]       r_shadow [NUM_FIELDS];
    logic [7:0]       r_field  [NUM_FIELDS];

    logic             w_frame_start;
    logic             w_any_bad;

    assign w_frame_start = r_vs_d & ~VS;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_vs_d <= 1'b1;
        end else begin
            r_vs_d <= VS;
        end
    end

    always_comb begin
        w_any_bad = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (!bcd_valid(r_shadow[i])) begin
                w_any_bad = 1'b1;
            end
        end
    end

    // REQ is raised on entry to ISSUE so that GAP is the only low cycle between requests.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_timer <= '0;
            r_req   <= 1'b0;
            r_addr  <= 8'h00;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                r_shadow[i] <= 8'h00;
                r_field[i]  <= 8'h00;
            end
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_state <= ST_ISSUE;
                        r_idx   <= '0;
                        r_req   <= 1'b1;
                        r_addr  <= rtc_addr('0);
                        r_busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_timer <= '0;
                end
                ST_WAIT: begin
                    if (ACK) begin
                        r_shadow[r_idx] <= RDATA;
                        r_req           <= 1'b0;
                        r_state         <= ST_GAP;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= ST_IDLE;
                        for (int i = 0; i < NUM_FIELDS; i++) begin
                            r_shadow[i] <= 8'h00;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_GAP: begin
                    if (r_idx == IDX_W'(LAST_IDX)) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_req   <= 1'b1;
                        r_addr  <= rtc_addr(r_idx + IDX_W'(1));
                        r_state <= ST_ISSUE;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_FIELDS; i++) begin
                        if (bcd_valid(r_shadow[i])) begin
                            r_field[i] <= r_shadow[i];
                        end
                    end
                    r_err   <= w_any_bad;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    alarm_blink #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .CLK        (CLK),
        .RST        (RST),
        .FRAME_START(w_frame_start),
        .ALARMA_IN  (ALARMA_IN),
        .ALARMA     (ALARMA)
    );

    assign REQ        = r_req;
    assign ADDR       = r_addr;
    assign BUSY       = r_busy;
    assign ERR        = r_err;
    assign DIA_T      = r_field[0];
    assign MES_T      = r_field[1];
    assign ANO_T      = r_field[2];
    assign HORA_T     = r_field[3];
    assign MINUTO_T   = r_field[4];
    assign SEGUNDO_T  = r_field[5];
    assign HORAT_T    = r_field[6];
    assign MINUTOT_T  = r_field[7];
    assign SEGUNDOT_T = r_field[8];

endmodule

// File: tb/tb_display_update_ctrl.sv
// tb/tb_display_update_ctrl.sv - directed vector bench for display_update_ctrl
module tb_display_update_ctrl;

    localparam int TIMEOUT      = 255;
    localparam int BLINK_FRAMES = 30;
    localparam logic [71:0] EXP_ADDRS = 72'h24_25_26_23_22_21_43_42_41;
    localparam logic [71:0] DATA_A    = 72'h15_08_24_13_45_30_00_05_59;
    localparam logic [71:0] DATA_B    = 72'h31_12_99_23_59_59_99_99_00;

    logic       CLK = 1'b0;
    logic       RST;
    logic       VS;
    logic       ALARMA_IN;
    logic       ACK;
    logic [7:0] RDATA;
    logic       REQ;
    logic [7:0] ADDR;
    logic [7:0] DIA_T, MES_T, ANO_T, HORA_T, MINUTO_T, SEGUNDO_T, HORAT_T, MINUTOT_T, SEGUNDOT_T;
    logic       ALARMA;
    logic       BUSY;
    logic       ERR;

    display_update_ctrl #(
        .TIMEOUT     (TIMEOUT),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .VS        (VS),
        .ALARMA_IN (ALARMA_IN),
        .REQ       (REQ),
        .ADDR      (ADDR),
        .ACK       (ACK),
        .RDATA     (RDATA),
        .DIA_T     (DIA_T),
        .MES_T     (MES_T),
        .ANO_T     (ANO_T),
        .HORA_T    (HORA_T),
        .MINUTO_T  (MINUTO_T),
        .SEGUNDO_T (SEGUNDO_T),
        .HORAT_T   (HORAT_T),
        .MINUTOT_T (MINUTOT_T),
        .SEGUNDOT_T(SEGUNDOT_T),
        .ALARMA    (ALARMA),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [71:0] data;
        logic [71:0] exp;
        int          hold_idx;
        int          exp_err;
        int          exp_reqs;
        int          exp_run;
        int          exp_chg;
    } vec_t;

    vec_t vecs [5];

    int          checks = 0;
    int          errors = 0;
    logic [71:0] rtc_data;
    logic [7:0]  hold_addr;
    int          rtc_wait;
    int          req_cnt, err_cnt, chg_cnt, cur_run, max_run;
    logic [71:0] rec_addrs;
    logic [71:0] prev_fields;
    logic        prev_req;
    logic [71:0] w_fields;

    assign w_fields = {DIA_T, MES_T, ANO_T, HORA_T, MINUTO_T, SEGUNDO_T, HORAT_T, MINUTOT_T, SEGUNDOT_T};

    function automatic logic [7:0] addr_at(input int i);
        logic [71:0] t;
        t = EXP_ADDRS;
        return t[71-8*i -: 8];
    endfunction

    function automatic logic [7:0] data_for(input logic [71:0] d, input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 9; i++) begin
            if (addr_at(i) == a) r = d[71-8*i -: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RTC model (acks two cycles after REQ is seen) plus bus monitor.
    initial begin : rtc_and_monitor
        ACK = 1'b0; RDATA = 8'h00; rtc_wait = 0;
        req_cnt = 0; err_cnt = 0; chg_cnt = 0; cur_run = 0; max_run = 0;
        rec_addrs = '0; prev_fields = '0; prev_req = 1'b0;
        forever begin
            @(negedge CLK);
            ACK = 1'b0;
            if (REQ && ADDR != hold_addr) begin
                if (rtc_wait >= 2) begin
                    ACK = 1'b1;
                    RDATA = data_for(rtc_data, ADDR);
                    rtc_wait = 0;
                end else begin
                    rtc_wait++;
                end
            end else begin
                rtc_wait = 0;
            end
            if (REQ && !prev_req) begin
                req_cnt++;
                rec_addrs = {rec_addrs[63:0], ADDR};
            end
            if (REQ) cur_run++;
            else begin
                if (cur_run > max_run) max_run = cur_run;
                cur_run = 0;
            end
            if (ERR) err_cnt++;
            if (w_fields !== prev_fields) chg_cnt++;
            prev_fields = w_fields;
            prev_req = REQ;
        end
    end

    task automatic clear_mon();
        @(negedge CLK);
        #1;
        req_cnt = 0; err_cnt = 0; chg_cnt = 0; cur_run = 0; max_run = 0;
        rec_addrs = '0; prev_fields = w_fields; prev_req = REQ;
    endtask

    task automatic frame_start();
        @(negedge CLK); VS = 1'b0;
        @(negedge CLK); VS = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin : main
        bit   ok;
        logic [7:0] a0;
        int   exp_alarm;

        vecs[0] = '{data: DATA_A, exp: DATA_A,
                    hold_idx: -1, exp_err: 0, exp_reqs: 9, exp_run: 3, exp_chg: 1};
        vecs[1] = '{data: 72'h16_09_25_14_46_6A_01_06_58, exp: 72'h16_09_25_14_46_30_01_06_58,
                    hold_idx: -1, exp_err: 1, exp_reqs: 9, exp_run: 3, exp_chg: 1};
        vecs[2] = '{data: 72'h20_10_26_11_12_13_02_03_04, exp: 72'h16_09_25_14_46_30_01_06_58,
                    hold_idx: 3, exp_err: 1, exp_reqs: 4, exp_run: TIMEOUT + 1, exp_chg: 0};
        vecs[3] = '{data: DATA_B, exp: DATA_B,
                    hold_idx: -1, exp_err: 0, exp_reqs: 9, exp_run: 3, exp_chg: 1};
        vecs[4] = '{data: 72'hA0_9F_99_00_00_00_00_00_00, exp: 72'h31_12_99_00_00_00_00_00_00,
                    hold_idx: -1, exp_err: 1, exp_reqs: 9, exp_run: 3, exp_chg: 1};

        RST = 1'b0; VS = 1'b1; ALARMA_IN = 1'b1; rtc_data = '0; hold_addr = 8'h00;
        repeat (3) @(negedge CLK);
        check("reset_fields", w_fields, 72'h0);
        check("reset_ctrl", {REQ, ADDR, BUSY, ERR, ALARMA}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        for (int v = 0; v < 5; v++) begin
            rtc_data  = vecs[v].data;
            hold_addr = (vecs[v].hold_idx < 0) ? 8'h00 : addr_at(vecs[v].hold_idx);
            clear_mon();
            frame_start();
            wait_idle(ok);
            check($sformatf("v%0d_done", v), ok, 1);
            check($sformatf("v%0d_fields", v), w_fields, vecs[v].exp);
            check($sformatf("v%0d_err", v), err_cnt, vecs[v].exp_err);
            check($sformatf("v%0d_reqs", v), req_cnt, vecs[v].exp_reqs);
            check($sformatf("v%0d_addrs", v), rec_addrs, EXP_ADDRS >> (8 * (9 - vecs[v].exp_reqs)));
            check($sformatf("v%0d_req_len", v), max_run, vecs[v].exp_run);
            check($sformatf("v%0d_updates", v), chg_cnt, vecs[v].exp_chg);
        end
        hold_addr = 8'h00;

        // Second frame start lands in WAIT and must be ignored.
        rtc_data = DATA_A;
        clear_mon();
        frame_start();
        a0 = ADDR;
        check("vs2_first_addr", a0, 8'h24);
        frame_start();
        check("vs2_addr_held", ADDR, a0);
        check("vs2_reqs_so_far", req_cnt, 1);
        wait_idle(ok);
        check("vs2_done", ok, 1);
        check("vs2_reqs", req_cnt, 9);
        check("vs2_addrs", rec_addrs, EXP_ADDRS);
        check("vs2_fields", w_fields, DATA_A);

        // Reset while the sixth request (index 5) is outstanding.
        rtc_data = DATA_B;
        clear_mon();
        frame_start();
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (req_cnt == 6) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("rst_reach_idx5", ok, 1);
        check("rst_addr_idx5", ADDR, 8'h21);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_fields", w_fields, 72'h0);
        check("rst_mid_ctrl", {REQ, ADDR, BUSY, ERR, ALARMA}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        frame_start();
        @(negedge CLK);
        check("rst_hold_fields", w_fields, 72'h0);
        check("rst_hold_ctrl", {REQ, ADDR, BUSY, ERR, ALARMA}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        clear_mon();
        frame_start();
        check("rst_restart_addr", ADDR, 8'h24);
        wait_idle(ok);
        check("rst_restart_done", ok, 1);
        check("rst_restart_reqs", req_cnt, 9);
        check("rst_restart_addrs", rec_addrs, EXP_ADDRS);
        check("rst_restart_fields", w_fields, DATA_B);

        // Alarm blink over 120 frames.
        ALARMA_IN = 1'b0;
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 120; k++) begin
            exp_alarm = ((k / BLINK_FRAMES) % 2 == 0) ? 0 : 1;
            check($sformatf("alarm_frame%0d", k), ALARMA, exp_alarm);
            frame_start();
            repeat (6) @(negedge CLK);
        end
        check("alarm_frame120", ALARMA, 0);
        for (int k = 0; k < 7; k++) begin
            frame_start();
            repeat (6) @(negedge CLK);
        end
        check("alarm_cnt7", u_dut.u_blink.r_cnt, 7);
        check("alarm_low_at7", ALARMA, 0);
        ALARMA_IN = 1'b1;
        repeat (2) @(negedge CLK);
        check("alarm_off_out", ALARMA, 1);
        check("alarm_off_cnt", u_dut.u_blink.r_cnt, 0);
        check("alarm_off_phase", u_dut.u_blink.r_phase, 0);

        wait_idle(ok);
        check("final_idle", ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
